// File: rtl/decoder_scan_sequencer_if.sv
// decoder_scan_sequencer_if
// Bundles the control handshake and the 74LS138 drive lines between the
// scan sequencer (slave) and whatever commands it (master).
//   start, stop, continuous : command inputs to the sequencer
//   hold                    : dwell freeze, present only when SCAN_HOLD_EN is defined
//   busy, done              : sequencer status
//   A, B, C                 : decoder address, A is the LSB
//   G, G2A, G2B             : decoder enables (G active-high, G2A/G2B active-low)
`timescale 1ns/1ps
interface decoder_scan_sequencer_if;
   logic start;
   logic stop;
   logic continuous;
`ifdef SCAN_HOLD_EN
   logic hold;
`endif
   logic busy;
   logic done;
   logic A;
   logic B;
   logic C;
   logic G;
   logic G2A;
   logic G2B;

`ifdef SCAN_HOLD_EN
   modport master (output start, stop, continuous, hold,
                   input  busy, done, A, B, C, G, G2A, G2B);
   modport slave  (input  start, stop, continuous, hold,
                   output busy, done, A, B, C, G, G2A, G2B);
`else
   modport master (output start, stop, continuous,
                   input  busy, done, A, B, C, G, G2A, G2B);
   modport slave  (input  start, stop, continuous,
                   output busy, done, A, B, C, G, G2A, G2B);
`endif
endinterface

// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer
// Drives a 74LS138-style 3-to-8 decoder: walks channels 0..LAST on {C,B,A},
// enables the decoder for DWELL cycles per channel and blanks it for one
// cycle between channels so adjacent Y outputs never overlap.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : decoder_scan_sequencer_if.slave (start/stop/continuous in,
//           busy/done/A/B/C/G/G2A/G2B out, all outputs registered)
// Parameters: DWELL (1..255) cycles per channel, LAST (0..7) highest channel.
// Optional feature macro SCAN_HOLD_EN: adds bus.hold, which freezes the
// dwell counter while high in DRIVE.
//
// state  | meaning
// IDLE   | decoder disabled, waiting for start
// DRIVE  | decoder enabled on the current channel, dwell counting down
// GAP    | one blanking cycle, address held, pick next channel or finish
// FINISH | one-cycle done pulse, decoder disabled
`timescale 1ns/1ps
module decoder_scan_sequencer #(
   parameter int DWELL = 4,
   parameter int LAST  = 7
) (
   input  logic                         clock,
   input  logic                         reset,
   decoder_scan_sequencer_if.slave      bus
);

   localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);
   localparam logic [2:0] LAST_CH  = 3'(LAST);

   typedef enum logic [1:0] {IDLE, DRIVE, GAP, FINISH} state_t;

   state_t     state_q, state_d;
   logic [2:0] chan_q, chan_d;
   logic [7:0] dwell_q, dwell_d;
   logic       cont_q, cont_d;
   logic       stop_pend_q, stop_pend_d;
   logic       en_q, en_n_q, busy_q, done_q;
   logic       hold_w;

`ifdef SCAN_HOLD_EN
   assign hold_w = bus.hold;
`else
   assign hold_w = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         chan_q      <= 3'd0;
         dwell_q     <= 8'd0;
         cont_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         en_q        <= 1'b0;
         en_n_q      <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         chan_q      <= chan_d;
         dwell_q     <= dwell_d;
         cont_q      <= cont_d;
         stop_pend_q <= stop_pend_d;
         // Output flops are loaded from the next state so they line up with
         // the state register; G and G2A/G2B share one edge and never split.
         en_q        <= (state_d == DRIVE);
         en_n_q      <= (state_d != DRIVE);
         busy_q      <= (state_d == DRIVE) || (state_d == GAP);
         done_q      <= (state_d == FINISH);
      end
   end

   always_comb begin
      state_d     = state_q;
      chan_d      = chan_q;
      dwell_d     = dwell_q;
      cont_d      = cont_q;
      stop_pend_d = stop_pend_q;
      case (state_q)
         IDLE: begin
            stop_pend_d = 1'b0;
            chan_d      = 3'd0;
            if (bus.start && !bus.stop) begin
               state_d = DRIVE;
               cont_d  = bus.continuous;
               dwell_d = DWELL_M1;
            end
         end
         DRIVE: begin
            if (bus.stop) stop_pend_d = 1'b1;
            if (!hold_w) begin
               if (dwell_q == 8'd0) state_d = GAP;
               else                 dwell_d = dwell_q - 8'd1;
            end
         end
         GAP: begin
            if (bus.stop) stop_pend_d = 1'b1;
            // A stop raised in the gap cycle itself still ends this channel.
            if (stop_pend_q || bus.stop || (chan_q == LAST_CH && !cont_q)) begin
               state_d = FINISH;
            end else begin
               state_d = DRIVE;
               dwell_d = DWELL_M1;
               chan_d  = (chan_q == LAST_CH) ? 3'd0 : chan_q + 3'd1;
            end
         end
         FINISH: begin
            stop_pend_d = 1'b0;
            chan_d      = 3'd0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.A    = chan_q[0];
   assign bus.B    = chan_q[1];
   assign bus.C    = chan_q[2];
   assign bus.G    = en_q;
   assign bus.G2A  = en_n_q;
   assign bus.G2B  = en_n_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
